// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// uart_tx_fifo: 8N1 UART transmitter (LSB first) fed by a small byte FIFO.
// Bit timing is driven by a shared x16 oversampling tick (clken), so each bit
// holds tx for OVERSAMPLE clken ticks and a frame is 10*OVERSAMPLE ticks.
// Ports:
//   clk_50m  system clock, rising edge
//   rst_n    synchronous reset, active-low
//   clken    baud x16 tick, one clk_50m cycle wide
//   wr_en    write strobe, din enqueued when FIFO not full
//   din      byte to transmit
//   full     FIFO holds FIFO_DEPTH entries (registered)
//   empty    FIFO holds no entries (registered)
//   busy     frame in progress (registered)
//   tx       serial line, idle high (registered)
module uart_tx_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       clken,
  input  logic       wr_en,
  input  logic [7:0] din,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       tx
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  state_t            state;
  logic [TICK_W-1:0] tick;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic              push_c;
  logic              pop_c;
  logic              tick_last_c;

  // Push uses the registered full flag, so a write while full is dropped even
  // when the state machine pops on the same edge.
  assign tick_last_c = (tick == TICK_LAST);
  assign push_c      = wr_en && !full;
  assign pop_c       = clken && !empty &&
                       ((state == IDLE) || ((state == STOP) && tick_last_c));

  // Next occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_nxt = count;
    case ({push_c, pop_c})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // FIFO storage; data needs no reset.
  always_ff @(posedge clk_50m) begin
    if (push_c) mem[wr_ptr] <= din;
  end

  // FIFO pointers, occupancy and registered flags.
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNT_FULL);
      empty <= (count_nxt == '0);
    end
  end

  // Frame state machine; tx and busy are set alongside each state change.
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      state   <= IDLE;
      tick    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else if (clken) begin
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (!empty) begin
            shift   <= mem[rd_ptr];
            bit_cnt <= '0;
            tick    <= '0;
            state   <= START;
            tx      <= 1'b0;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (tick_last_c) begin
            tick  <= '0;
            state <= DATA;
            tx    <= shift[0];
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end
        DATA: begin
          if (tick_last_c) begin
            tick <= '0;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end
        STOP: begin
          if (tick_last_c) begin
            tick <= '0;
            if (!empty) begin
              // Back-to-back frame: next start bit follows the stop bit directly.
              shift   <= mem[rd_ptr];
              bit_cnt <= '0;
              state   <= START;
              tx      <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              tx    <= 1'b1;
            end
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          tick  <= '0;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo. A frame-position
// reference model predicts tx/busy/full/empty every cycle; a line decoder
// recovers bytes for the loopback sequence.
module tb_uart_tx_fifo;

  localparam int DEPTH = 4;
  localparam int OS    = 16;
  localparam int FRAME = 10 * OS;

  logic       clk_50m = 1'b0;
  logic       rst_n;
  logic       clken;
  logic       wr_en;
  logic [7:0] din;
  logic       full;
  logic       empty;
  logic       busy;
  logic       tx;

  uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .OVERSAMPLE(OS)) dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .clken(clken), .wr_en(wr_en),
    .din(din), .full(full), .empty(empty), .busy(busy), .tx(tx)
  );

  always #10 clk_50m = ~clk_50m;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;
  bit rx_on  = 1'b0;
  int cmode  = 0;   // 0 off, 1 every 4th, 2 every cycle, 3 random, 4 manual
  int gen_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_50m);
    #1;
  endtask

  // clken pattern generator
  initial begin
    clken = 1'b0;
    forever begin
      @(posedge clk_50m);
      #1;
      case (cmode)
        0: clken = 1'b0;
        1: clken = ((gen_cnt % 4) == 3);
        2: clken = 1'b1;
        3: clken = ($urandom_range(2) == 0);
        default: ;
      endcase
      gen_cnt++;
    end
  end

  // Reference model: byte queue plus position (in ticks) inside the current frame.
  logic [7:0] m_q[$];
  bit         m_act = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_cur = 8'h00;
  bit         m_had;
  bit         m_can_wr;

  initial forever begin
    @(posedge clk_50m);
    if (!rst_n) begin
      m_q.delete();
      m_act = 1'b0;
      m_pos = 0;
    end else begin
      m_had    = (m_q.size() != 0);
      m_can_wr = wr_en && (m_q.size() < DEPTH);
      if (clken) begin
        if (m_act) begin
          m_pos++;
          if (m_pos == FRAME) begin
            m_pos = 0;
            if (m_had) m_cur = m_q.pop_front();
            else       m_act = 1'b0;
          end
        end else if (m_had) begin
          m_cur = m_q.pop_front();
          m_act = 1'b1;
          m_pos = 0;
        end
      end
      if (m_can_wr) m_q.push_back(din);
    end
  end

  function automatic logic model_tx();
    int b;
    if (!m_act) return 1'b1;
    b = m_pos / OS;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
    return 1'b1;
  endfunction

  // Per-cycle comparison against the model.
  initial forever begin
    logic [3:0] got, exp;
    @(negedge clk_50m);
    if (chk_on) begin
      got = {tx, busy, full, empty};
      exp = {model_tx(), m_act, (m_q.size() == DEPTH), (m_q.size() == 0)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL line_state t=%0t tx/busy/full/empty got %b expected %b", $time, got, exp);
      end
    end
  end

  // Line decoder: detect start, sample mid-bit.
  logic [7:0] rxq[$];
  logic [7:0] rx_byte;

  task automatic rx_wait(input int n);
    int k = 0;
    while (k < n) begin
      @(negedge clk_50m);
      if (clken === 1'b1) k++;
    end
  endtask

  initial forever begin
    @(negedge clk_50m);
    if (rx_on && clken === 1'b1 && tx === 1'b0) begin
      rx_wait(8);
      chk("rx_start_bit", 32'(tx), 32'd0);
      for (int b = 0; b < 8; b++) begin
        rx_wait(16);
        rx_byte[b] = tx;
      end
      rx_wait(16);
      chk("rx_stop_bit", 32'(tx), 32'd1);
      rxq.push_back(rx_byte);
    end
  end

  task automatic write_byte(input logic [7:0] d);
    wr_en = 1'b1;
    din   = d;
    step();
    wr_en = 1'b0;
  endtask

  // Count clken ticks from busy rising until it falls.
  task automatic measure_busy(output int n, input int budget);
    int w = 0;
    n = 0;
    while (busy !== 1'b1 && w < 400) begin
      @(negedge clk_50m);
      w++;
    end
    if (busy !== 1'b1) begin
      chk("busy_rise_timeout", 32'(busy), 32'd1);
      return;
    end
    w = 0;
    while (busy === 1'b1 && w < budget) begin
      if (clken === 1'b1) n++;
      @(negedge clk_50m);
      w++;
    end
    #11;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int w = 0;
    while (!(busy === 1'b0 && empty === 1'b1) && w < budget) begin
      step();
      w++;
    end
    chk(name, 32'({busy, empty}), 32'b01);
  endtask

  task automatic pulse_tick();
    clken = 1'b1;
    step();
    clken = 1'b0;
  endtask

  task automatic tick_to_stop_end(input string name);
    int k = 0;
    while (!(m_act && m_pos == FRAME - 1) && k < 400) begin
      pulse_tick();
      k++;
    end
    chk(name, 32'(m_pos), 32'(FRAME - 1));
  endtask

  typedef struct {
    logic       rst_n;
    logic       wr_en;
    logic [7:0] din;
    logic       full;
    logic       empty;
    logic       busy;
    logic       tx;
  } vec_t;

  vec_t tbl[11];
  int   n;
  int   w;

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0;
    din   = 8'h00;

    // Reset, idle hold, then fill with clken frozen; fifth write must drop.
    tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 11; i++) begin
      rst_n = tbl[i].rst_n;
      wr_en = tbl[i].wr_en;
      din   = tbl[i].din;
      step();
      chk($sformatf("vec%0d_full", i),  32'(full),  32'(tbl[i].full));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(tbl[i].empty));
      chk($sformatf("vec%0d_busy", i),  32'(busy),  32'(tbl[i].busy));
      chk($sformatf("vec%0d_tx", i),    32'(tx),    32'(tbl[i].tx));
      if (i == 0) chk_on = 1'b1;
    end
    wr_en = 1'b0;

    // Four queued frames go out contiguously.
    cmode = 1;
    measure_busy(n, 4000);
    chk("contig_4_frames_ticks", 32'(n), 32'(4 * FRAME));
    chk("contig_empty_after", 32'(empty), 32'd1);

    // Single byte frame length.
    write_byte(8'h55);
    chk("single_empty_after_write", 32'(empty), 32'd0);
    measure_busy(n, 2000);
    chk("single_frame_ticks", 32'(n), 32'(FRAME));

    // Loopback of all byte values through the line decoder.
    step();
    cmode = 2;
    rx_on = 1'b1;
    for (int i = 0; i < 256; i++) begin
      w = 0;
      while (full === 1'b1 && w < 2 * FRAME) begin
        step();
        w++;
      end
      write_byte(8'(i));
    end
    w = 0;
    while (rxq.size() < 256 && w < 8 * FRAME) begin
      step();
      w++;
    end
    chk("loop_count", 32'(rxq.size()), 32'd256);
    for (int i = 0; i < 256 && i < rxq.size(); i++)
      chk($sformatf("loop_byte%0d", i), 32'(rxq[i]), 32'(i));
    wait_idle("loop_idle", 4 * FRAME);
    rx_on = 1'b0;

    // Reset during data bit 3 of 0xF0 with two bytes queued.
    cmode = 1;
    write_byte(8'hF0);
    write_byte(8'hAA);
    write_byte(8'h55);
    w = 0;
    while (!(m_act && m_pos == 70) && w < 2000) begin
      step();
      w++;
    end
    chk("abort_reached_bit3", 32'(m_pos), 32'd70);
    chk("abort_queued", 32'(m_q.size()), 32'd2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_empty", 32'(empty), 32'd1);
    chk("abort_full", 32'(full), 32'd0);
    write_byte(8'h0F);
    measure_busy(n, 2000);
    chk("after_abort_frame_ticks", 32'(n), 32'(FRAME));

    // Writes landing on the STOP-end pop edge.
    step();
    cmode = 4;
    clken = 1'b0;
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    write_byte(8'h44);
    pulse_tick();
    write_byte(8'h55);
    chk("pop_edge_full_before", 32'(full), 32'd1);
    tick_to_stop_end("pop_edge_align1");
    clken = 1'b1;
    write_byte(8'h66);
    clken = 1'b0;
    chk("pop_edge_drop_full", 32'(full), 32'd0);
    chk("pop_edge_drop_empty", 32'(empty), 32'd0);
    tick_to_stop_end("pop_edge_align2");
    clken = 1'b1;
    write_byte(8'h77);
    clken = 1'b0;
    chk("pop_edge_accept_full", 32'(full), 32'd0);
    write_byte(8'h88);
    chk("pop_edge_refill_full", 32'(full), 32'd1);
    cmode = 1;
    wait_idle("pop_edge_drain", 8 * 4 * FRAME);

    // Random traffic and random tick spacing.
    for (int i = 0; i < 12000; i++) begin
      wr_en = ($urandom_range(2) != 0);
      din   = 8'($urandom);
      step();
    end
    cmode = 3;
    for (int i = 0; i < 8000; i++) begin
      wr_en = ($urandom_range(3) == 0);
      din   = 8'($urandom);
      step();
    end
    wr_en = 1'b0;
    wait_idle("random_drain", 6 * 4 * FRAME);

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
